aq_vlsu_rot_merge: RTL and testbench
====================================

Name: aq_vlsu_rot_merge

Overview:
Parametrised successor to the LSU byte-rotate datapath. It takes a stream of misaligned memory beats, byte-rotates each beat by a start offset, and merges each beat with the next into aligned output beats with byte-valid masks. It sits between the VLSU load data return and the vector register write-back merge. Valid/ready handshakes are used on both sides, with one registered output stage.

Parameters:
DATAW, 128, beat width in bits; multiple of 8, power of two, range 64..512
BYTES, DATAW/8, bytes per beat (derived)
OFFW, log2(BYTES), width of byte offset (derived)

Ports:
forever_cpuclk  input  1  clock
cpurst  input  1  asynchronous active-high reset
in_vld  input  1  input beat valid
in_rdy  output  1  input beat accepted when in_vld & in_rdy
in_data  input  DATAW  raw memory beat
in_off  input  OFFW  start byte offset; sampled only on accepted beat with in_first=1
in_first  input  1  first beat of an access
in_last  input  1  last beat of an access
in_drain  input  1  sampled with in_last; 1 = emit an extra partial beat from carry
in_kill  input  1  synchronous flush
out_vld  output  1  output beat valid
out_rdy  input  1  downstream ready
out_data  output  DATAW  aligned data
out_bmask  output  BYTES  byte valid mask, bit j covers out_data[8j+7:8j]
out_last  output  1  final output beat of the access

Behaviour:
- Handshake and reset:
  - Accept = in_vld & in_rdy. Output transfer = out_vld & out_rdy.
  - in_rdy = (state != DRAIN) & (~out_vld | out_rdy) & ~in_kill. This is combinational; there is no skid buffer.
  - Reset values: state IDLE, carry 0, off_q 0, out_vld 0, out_data 0, out_bmask 0, out_last 0.
- Rotation: rot(x) byte j = x byte ((j+off) mod BYTES), i.e. a right-rotate by off bytes. off = in_off on a first beat, otherwise off_q.
- Merge: merged byte j = carry byte j for j < BYTES-off; otherwise rot(in_data) byte j.
- Load output register: out_vld<=1 and out_data/out_bmask/out_last update only when the slot is free (~out_vld | out_rdy). If the slot is free and nothing is loaded, out_vld<=0. out_* hold stable while out_vld & ~out_rdy.
- State IDLE:
  - Accepting a beat latches off_q<=in_off. A beat without in_first is treated as first.
  - off==0: load out=in_data, bmask all ones, out_last=in_last. Stay IDLE.
  - off!=0 & ~in_last: carry<=rot(in_data), no output, go CARRY.
  - off!=0 & in_last: carry<=rot(in_data), go DRAIN. This path ignores in_drain.
- State CARRY (accepted beat):
  - Always: load out=merged, bmask all ones; carry<=rot(in_data).
  - ~in_last: out_last=0, stay CARRY.
  - in_last & ~in_drain: out_last=1, go IDLE.
  - in_last & in_drain: out_last=0, go DRAIN.
  - An in_first beat arriving in CARRY is a protocol error. It is handled as a plain continuation beat, and the bench asserts it never occurs.
- State DRAIN:
  - When the slot is free: load out = carry with bytes j >= BYTES-off forced to 0, bmask = low (BYTES-off) bits set, out_last=1, go IDLE.
  - in_rdy=0 throughout DRAIN.
- Latency: 1 cycle from accept to out_vld for off==0 and for CARRY merges. A pure-carry beat produces no output.
- in_kill: at the next edge, state<=IDLE, out_vld<=0, carry retained but don't-care. in_kill dominates a simultaneous accept or output transfer.
- Reset mid-access: all state returns to reset values asynchronously. The next accepted beat is handled as a first beat.

Test Plan:
1. DATAW=64, off=0, two beats 0x0706050403020100 / 0x0F0E0D0C0B0A0908, out_rdy=1 -> two outputs identical to the inputs, bmask 0xFF, out_last on the second only, each 1 cycle after accept.
2. DATAW=64, off=3, same two beats, in_last+in_drain on the second -> out 0x0A09080706050403 bmask 0xFF last=0, then 0x0000000F0E0D0C0B bmask 0x1F last=1; in_rdy low during DRAIN.
3. As scenario 2 but in_drain=0 -> single output 0x0A09080706050403, bmask 0xFF, out_last=1; state IDLE the next cycle.
4. Single beat first+last, off=5, data 0x0706050403020100 -> out 0x0000000000070605, bmask 0x07, last=1.
5. Backpressure: scenario 2 with out_rdy=0 for 4 cycles -> in_rdy=0, out_* stable for 4 cycles, no beat lost or duplicated after release.
6. in_kill in CARRY, and cpurst asserted mid-access in a separate run -> out_vld=0 next cycle / immediately; a fresh off=0 beat afterwards passes through unmodified.

Source files
------------

// File: rtl/aq_vlsu_rot_merge_if.sv
// Valid/ready beat interface between VLSU load return (in_*) and write-back merge (out_*).
// The slave modport is the rotate/merge block; the master modport is its environment.
interface aq_vlsu_rot_merge_if #(
    parameter int DATAW = 128
);
    localparam int BYTES = DATAW / 8;
    localparam int OFFW  = $clog2(BYTES);

    logic             in_vld;
    logic             in_rdy;
    logic [DATAW-1:0] in_data;
    logic [OFFW-1:0]  in_off;
    logic             in_first;
    logic             in_last;
    logic             in_drain;
    logic             in_kill;
    logic             out_vld;
    logic             out_rdy;
    logic [DATAW-1:0] out_data;
    logic [BYTES-1:0] out_bmask;
    logic             out_last;

    modport slave (
        input  in_vld, in_data, in_off, in_first, in_last, in_drain, in_kill, out_rdy,
        output in_rdy, out_vld, out_data, out_bmask, out_last
    );

    modport master (
        output in_vld, in_data, in_off, in_first, in_last, in_drain, in_kill, out_rdy,
        input  in_rdy, out_vld, out_data, out_bmask, out_last
    );
endinterface

// File: rtl/aq_vlsu_rot_merge.sv
// Byte-rotates misaligned memory beats by a start offset and merges consecutive beats
// into aligned output beats with byte masks, through one registered output stage.
module aq_vlsu_rot_merge #(
    parameter int DATAW = 128
) (
    input  logic                  forever_cpuclk_i,
    input  logic                  cpurst_i,
    aq_vlsu_rot_merge_if.slave    bus
);
    localparam int BYTES = DATAW / 8;
    localparam int OFFW  = $clog2(BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CARRY = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DATAW-1:0] carry_q, carry_d;
    logic [OFFW-1:0]  off_q, off_d;
    logic             out_vld_q;
    logic [DATAW-1:0] out_data_q;
    logic [BYTES-1:0] out_bmask_q;
    logic             out_last_q;

    logic               slot_free;
    logic               accept;
    logic [OFFW-1:0]    off_sel;
    logic [2*DATAW-1:0] rot_dbl;
    logic [DATAW-1:0]   rot_in;
    logic [BYTES-1:0]   keep_mask;
    logic [DATAW-1:0]   keep_bits;
    logic [DATAW-1:0]   merged;
    logic               ld;
    logic [DATAW-1:0]   ld_data;
    logic [BYTES-1:0]   ld_mask;
    logic               ld_last;

    assign slot_free  = ~out_vld_q | bus.out_rdy;
    assign bus.in_rdy = (state_q != DRAIN) & slot_free & ~bus.in_kill;
    assign accept     = bus.in_vld & bus.in_rdy;

    // Every beat taken in IDLE starts an access, so it uses the live offset.
    assign off_sel   = (state_q == IDLE) ? bus.in_off : off_q;
    assign rot_dbl   = {bus.in_data, bus.in_data} >> {off_sel, 3'b000};
    assign rot_in    = rot_dbl[DATAW-1:0];
    assign keep_mask = {BYTES{1'b1}} >> off_sel;

    always_comb begin
        keep_bits = '0;
        for (int j = 0; j < BYTES; j++) begin
            keep_bits[8*j +: 8] = {8{keep_mask[j]}};
        end
    end

    assign merged = (carry_q & keep_bits) | (rot_in & ~keep_bits);

    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        off_d   = off_q;
        ld      = 1'b0;
        ld_data = merged;
        ld_mask = {BYTES{1'b1}};
        ld_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    off_d = bus.in_off;
                    if (bus.in_off == '0) begin
                        ld      = 1'b1;
                        ld_data = bus.in_data;
                        ld_last = bus.in_last;
                    end else begin
                        carry_d = rot_in;
                        state_d = bus.in_last ? DRAIN : CARRY;
                    end
                end
            end
            CARRY: begin
                if (accept) begin
                    ld      = 1'b1;
                    carry_d = rot_in;
                    if (bus.in_last) begin
                        if (bus.in_drain) begin
                            state_d = DRAIN;
                        end else begin
                            ld_last = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            DRAIN: begin
                if (slot_free) begin
                    ld      = 1'b1;
                    ld_data = carry_q & keep_bits;
                    ld_mask = keep_mask;
                    ld_last = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.in_kill) begin
            state_d = IDLE;
            ld      = 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk_i or posedge cpurst_i) begin
        if (cpurst_i) begin
            state_q <= IDLE;
            carry_q <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            off_q   <= off_d;
        end
    end

    always_ff @(posedge forever_cpuclk_i or posedge cpurst_i) begin
        if (cpurst_i) begin
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_bmask_q <= '0;
            out_last_q  <= 1'b0;
        end else if (bus.in_kill) begin
            out_vld_q <= 1'b0;
        end else if (slot_free) begin
            out_vld_q <= ld;
            if (ld) begin
                out_data_q  <= ld_data;
                out_bmask_q <= ld_mask;
                out_last_q  <= ld_last;
            end
        end
    end

    assign bus.out_vld   = out_vld_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_bmask = out_bmask_q;
    assign bus.out_last  = out_last_q;

    // A first beat in the middle of an access is a protocol error upstream.
    a_no_first_in_carry: assert property (
        @(posedge forever_cpuclk_i) disable iff (cpurst_i)
        !(accept && (state_q == CARRY) && bus.in_first)
    );
endmodule

// File: tb/tb_aq_vlsu_rot_merge.sv
// Scenario bench for aq_vlsu_rot_merge at DATAW=64 with an output scoreboard.
module tb_aq_vlsu_rot_merge;
    localparam int DATAW = 64;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  m;
        logic        l;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    localparam logic [63:0] B0 = 64'h0706050403020100;
    localparam logic [63:0] B1 = 64'h0F0E0D0C0B0A0908;
    localparam logic [63:0] B2 = 64'h8877665544332211;

    aq_vlsu_rot_merge_if #(.DATAW(DATAW)) ifc ();

    aq_vlsu_rot_merge #(.DATAW(DATAW)) dut (
        .forever_cpuclk_i (clk),
        .cpurst_i         (rst),
        .bus              (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Scoreboard: every output transfer must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && ifc.out_vld && ifc.out_rdy) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got data=%h mask=%h last=%b, required no output",
                         ifc.out_data, ifc.out_bmask, ifc.out_last);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({ifc.out_data, ifc.out_bmask, ifc.out_last} !== {e.d, e.m, e.l}) begin
                    failures++;
                    $display("FAIL sb_beat: got data=%h mask=%h last=%b, required data=%h mask=%h last=%b",
                             ifc.out_data, ifc.out_bmask, ifc.out_last, e.d, e.m, e.l);
                end
            end
        end
    end

    task automatic push_exp(input logic [63:0] d, input logic [7:0] m, input logic l);
        exp_t e;
        e.d = d; e.m = m; e.l = l;
        sb_q.push_back(e);
    endtask

    // Presents one beat and returns 1 time unit after the edge that accepted it.
    task automatic drive_beat(input logic [63:0] d, input logic [2:0] off, input logic first,
                              input logic last, input logic drain);
        bit ok;
        @(posedge clk); #1;
        ifc.in_vld   = 1'b1;
        ifc.in_data  = d;
        ifc.in_off   = off;
        ifc.in_first = first;
        ifc.in_last  = last;
        ifc.in_drain = drain;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.in_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_rdy stayed low, required acceptance within 50 cycles");
        end
        @(posedge clk); #1;
        ifc.in_vld   = 1'b0;
        ifc.in_first = 1'b0;
        ifc.in_last  = 1'b0;
        ifc.in_drain = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_drain: %0d outputs still pending, required 0", name, sb_q.size());
            sb_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks += 5;
        if (ifc.out_vld !== 1'b0) begin
            failures++; $display("FAIL reset_out_vld: got %b, required 0", ifc.out_vld);
        end
        if (ifc.out_data !== 64'h0) begin
            failures++; $display("FAIL reset_out_data: got %h, required 0", ifc.out_data);
        end
        if (ifc.out_bmask !== 8'h00) begin
            failures++; $display("FAIL reset_out_bmask: got %h, required 00", ifc.out_bmask);
        end
        if (ifc.out_last !== 1'b0) begin
            failures++; $display("FAIL reset_out_last: got %b, required 0", ifc.out_last);
        end
        if (ifc.in_rdy !== 1'b1) begin
            failures++; $display("FAIL reset_in_rdy: got %b, required 1", ifc.in_rdy);
        end
    endtask

    task automatic test_aligned();
        ifc.out_rdy = 1'b1;
        push_exp(B0, 8'hFF, 1'b0);
        drive_beat(B0, 3'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ifc.out_vld !== 1'b1) begin
            failures++; $display("FAIL aligned_latency0: out_vld got %b, required 1 one cycle after accept", ifc.out_vld);
        end
        push_exp(B1, 8'hFF, 1'b1);
        drive_beat(B1, 3'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ifc.out_vld, ifc.out_last} !== 2'b11) begin
            failures++; $display("FAIL aligned_latency1: out_vld/out_last got %b%b, required 11", ifc.out_vld, ifc.out_last);
        end
        wait_empty("aligned");
    endtask

    task automatic test_drain();
        ifc.out_rdy = 1'b1;
        push_exp(64'h0A09080706050403, 8'hFF, 1'b0);
        push_exp(64'h0000000F0E0D0C0B, 8'h1F, 1'b1);
        drive_beat(B0, 3'd3, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ifc.out_vld !== 1'b0) begin
            failures++; $display("FAIL drain_carry_no_out: out_vld got %b, required 0", ifc.out_vld);
        end
        drive_beat(B1, 3'd0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({ifc.out_vld, ifc.in_rdy} !== 2'b10) begin
            failures++; $display("FAIL drain_in_rdy: out_vld/in_rdy got %b%b, required 10", ifc.out_vld, ifc.in_rdy);
        end
        wait_empty("drain");
    endtask

    task automatic test_no_drain();
        ifc.out_rdy = 1'b1;
        push_exp(64'h0A09080706050403, 8'hFF, 1'b1);
        drive_beat(B0, 3'd3, 1'b1, 1'b0, 1'b0);
        drive_beat(B1, 3'd0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ifc.out_vld, ifc.out_last, ifc.in_rdy} !== 3'b111) begin
            failures++; $display("FAIL nodrain_idle: out_vld/out_last/in_rdy got %b%b%b, required 111",
                                 ifc.out_vld, ifc.out_last, ifc.in_rdy);
        end
        @(posedge clk); #1;
        checks++;
        if (ifc.out_vld !== 1'b0) begin
            failures++; $display("FAIL nodrain_extra: out_vld got %b, required 0", ifc.out_vld);
        end
        wait_empty("nodrain");
    endtask

    task automatic test_single();
        ifc.out_rdy = 1'b1;
        push_exp(64'h0000000000070605, 8'h07, 1'b1);
        drive_beat(B0, 3'd5, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({ifc.out_vld, ifc.in_rdy} !== 2'b00) begin
            failures++; $display("FAIL single_drain_state: out_vld/in_rdy got %b%b, required 00", ifc.out_vld, ifc.in_rdy);
        end
        wait_empty("single");
    endtask

    task automatic test_backpressure();
        ifc.out_rdy = 1'b0;
        push_exp(64'h0A09080706050403, 8'hFF, 1'b0);
        push_exp(64'h0000000F0E0D0C0B, 8'h1F, 1'b1);
        drive_beat(B0, 3'd3, 1'b1, 1'b0, 1'b0);
        drive_beat(B1, 3'd0, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({ifc.in_rdy, ifc.out_vld, ifc.out_data, ifc.out_bmask, ifc.out_last} !==
                {1'b0, 1'b1, 64'h0A09080706050403, 8'hFF, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold%0d: in_rdy=%b out_vld=%b data=%h mask=%h last=%b, required 0 1 0a09080706050403 ff 0",
                         c, ifc.in_rdy, ifc.out_vld, ifc.out_data, ifc.out_bmask, ifc.out_last);
            end
        end
        @(posedge clk); #1;
        ifc.out_rdy = 1'b1;
        wait_empty("bp");
    endtask

    task automatic test_kill();
        ifc.out_rdy = 1'b1;
        drive_beat(B0, 3'd3, 1'b1, 1'b0, 1'b0);
        ifc.in_kill  = 1'b1;
        ifc.in_vld   = 1'b1;
        ifc.in_data  = B1;
        ifc.in_last  = 1'b1;
        @(negedge clk);
        checks++;
        if (ifc.in_rdy !== 1'b0) begin
            failures++; $display("FAIL kill_in_rdy: got %b, required 0", ifc.in_rdy);
        end
        @(posedge clk); #1;
        ifc.in_kill = 1'b0;
        ifc.in_vld  = 1'b0;
        ifc.in_last = 1'b0;
        checks++;
        if (ifc.out_vld !== 1'b0) begin
            failures++; $display("FAIL kill_out_vld: got %b, required 0", ifc.out_vld);
        end
        push_exp(B2, 8'hFF, 1'b1);
        drive_beat(B2, 3'd0, 1'b1, 1'b1, 1'b0);
        wait_empty("kill");
    endtask

    task automatic test_reset_mid();
        ifc.out_rdy = 1'b0;
        drive_beat(B0, 3'd3, 1'b1, 1'b0, 1'b0);
        drive_beat(B1, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (ifc.out_vld !== 1'b1) begin
            failures++; $display("FAIL rstmid_pre: out_vld got %b, required 1", ifc.out_vld);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ifc.out_vld, ifc.out_data, ifc.out_bmask} !== {1'b0, 64'h0, 8'h00}) begin
            failures++; $display("FAIL rstmid_async: out_vld=%b data=%h mask=%h, required 0 0 00",
                                 ifc.out_vld, ifc.out_data, ifc.out_bmask);
        end
        @(negedge clk);
        rst = 1'b0;
        ifc.out_rdy = 1'b1;
        push_exp(B2, 8'hFF, 1'b1);
        drive_beat(B2, 3'd0, 1'b0, 1'b1, 1'b0);
        wait_empty("rstmid");
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        ifc.in_vld   = 1'b0;
        ifc.in_data  = '0;
        ifc.in_off   = '0;
        ifc.in_first = 1'b0;
        ifc.in_last  = 1'b0;
        ifc.in_drain = 1'b0;
        ifc.in_kill  = 1'b0;
        ifc.out_rdy  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_aligned();
        test_drain();
        test_no_drain();
        test_single();
        test_backpressure();
        test_kill();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL sb_leftover: %0d pending, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
